// File: rtl/serial_add_pkg.sv
// Shared FSM state type and width helpers for the serial adder scheduler.
package serial_add_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        FLUSH,
        DONE
    } state_t;

    // Bits needed to count WIDTH serial steps down to zero.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, searching
// upward with wrap. The grant is only driven while advance is high.
module rr_arbiter
    import serial_add_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner
);

    logic found;
    int   idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                winner     = IDW'(idx);
                grant[idx] = advance;
            end
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Subtract support is compiled in when SERIAL_ADD_CTRL_SUB_EN is defined.
//
//   state | meaning
//   IDLE  | arbitrate, accept one operand pair
//   CLEAR | preset adder carry
//   SHIFT | stream WIDTH operand bits LSB-first, collect sum bits
//   FLUSH | collect final carry as result MSB
//   DONE  | hold result until rsp handshake
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    output logic                  add_in1,
    output logic                  add_in2,
    output logic                  add_clr,
    output logic                  add_cin,
    input  logic                  add_sum
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   id_q;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_shift;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             advance;
    logic             sub_bit;

    // Reset also masks the grant so req_ready is low while rst_n is low.
    assign advance   = (state == IDLE) && rst_n;
    assign accept    = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .advance (advance),
        .grant   (grant),
        .winner  (winner)
    );

`ifdef SERIAL_ADD_CTRL_SUB_EN
    logic sub_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= req_sub[winner];
        end
    end

    assign sub_bit = sub_q;
`else
    logic unused_sub;

    assign unused_sub = ^req_sub;
    assign sub_bit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        add_in1   = 1'b0;
        add_in2   = 1'b0;
        add_clr   = 1'b0;
        add_cin   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                add_clr   = 1'b1;
                add_cin   = sub_bit;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                add_in1 = sa[0];
                add_in2 = sb[0] ^ sub_bit;
                if (cnt == '0) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                // rsp_valid is high for the whole of DONE.
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!rst_n) begin
            add_in1 = 1'b0;
            add_in2 = 1'b0;
            add_clr = 1'b0;
            add_cin = 1'b0;
        end
    end

    // Sum bits enter at the top so the first bit ends up at bit 0.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = add_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            sa        <= '0;
            sb        <= '0;
            res_q     <= '0;
            cnt       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa   <= req_a[winner*WIDTH +: WIDTH];
                        sb   <= req_b[winner*WIDTH +: WIDTH];
                        id_q <= winner;
                        ptr  <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= CNT_LAST;
                end
                SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    res_q <= res_shift;
                    cnt   <= cnt - 1'b1;
                end
                FLUSH: begin
                    rsp_valid <= 1'b1;
                    rsp_sum   <= {add_sum, res_q};
                    rsp_id    <= id_q;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Round-robin scheduler that shares one bit-serial adder among `NREQ` requesters. It accepts parallel operand pairs over valid/ready, clears the adder carry, and shifts the operands LSB-first into the adder. It collects the serial sum into a `WIDTH+1`-bit parallel result and returns that result with the requester's ID. It sits between the parallel datapath clients and the shared `serial_adder` instance.

## Interface
- `WIDTH`, 8: operand width in bits; must be ≥ 1.
- `NREQ`, 2: number of requesters; must be ≥ 1.
- `IDW`, derived as `$clog2(NREQ)` (minimum 1): width of the requester ID.
- `clk`  in  1  single clock; all logic is rising-edge triggered.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`, `req_b`  in  NREQ*WIDTH  flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_sub`  in  NREQ  per-requester subtract select; honoured only with the config macro.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_sum`  out  WIDTH+1  result; bit WIDTH is the final carry.
- `add_in1`, `add_in2`  out  1  serial operand bits driven to the adder.
- `add_clr`  out  1  when high, the adder's carry register loads `add_cin` at the next edge.
- `add_cin`  out  1  carry preset value.
- `add_sum`  in  1  adder sum output; combinational in `add_in1`, `add_in2` and the adder's registered carry.

## Operation
- FSM states and transitions:
  - IDLE: waits for a request; moves to CLEAR on accept.
  - CLEAR: lasts 1 cycle; moves to SHIFT.
  - SHIFT: lasts WIDTH cycles; moves to FLUSH.
  - FLUSH: lasts 1 cycle; moves to DONE.
  - DONE: moves to IDLE when `rsp_valid & rsp_ready`.
- Arbitration in IDLE:
  - Grant goes to the first asserted `req_valid` at or after pointer `ptr`, searching upward with wrap.
  - `req_ready` is asserted only to the granted requester, and only in IDLE.
  - `req_ready` is combinational from `req_valid` and `ptr`.
  - On accept, `ptr` ← (winner + 1) mod NREQ.
  - `ptr` is unchanged when no request is valid.
- Accept captures the operands into shift registers `sa` and `sb`, plus the ID and the sub flag.
- CLEAR:
  - `add_clr` = 1 and `add_cin` = 0.
  - `add_in1` = `add_in2` = 0.
- SHIFT, bit count k = 0..WIDTH-1:
  - Drive `add_in1` = `sa[0]` and `add_in2` = `sb[0]`.
  - Capture `add_sum` into result bit k.
  - Shift `sa` and `sb` right by one bit.
- FLUSH:
  - Drive `add_in1` = `add_in2` = 0.
  - Capture `add_sum` into result bit WIDTH; this is the final carry.
- DONE:
  - `rsp_valid` = 1.
  - `rsp_sum` and `rsp_id` are held stable until the handshake completes.
  - No new request is accepted in DONE, even when `rsp_ready` is high in the same cycle.
- Arithmetic is unsigned: `rsp_sum` = a + b, with no truncation.
- Reset, including reset mid-transaction, returns the block to:
  - state IDLE, `ptr` = 0, and an all-zero result register;
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0;
  - `req_ready` = 0 during reset;
  - all `add_*` outputs = 0.
  - Any in-flight transaction is dropped silently.

## Timing
- Accept at edge T:
  - CLEAR occupies cycle T+1.
  - SHIFT bit k is driven in cycle T+2+k.
  - FLUSH occupies cycle T+2+WIDTH.
  - `rsp_valid` rises at T+3+WIDTH, giving a latency of WIDTH+3 cycles.
- Minimum spacing between accepts is WIDTH+4 cycles, reached when `rsp_ready` is held high.
- `req_ready` and `add_*` are driven by the FSM state; `rsp_*` are registered.

## Configuration
- `SERIAL_ADD_CTRL_SUB_EN` defined:
  - When the captured sub flag is 1, `add_in2` = ~`sb[0]` in SHIFT and `add_cin` = 1 in CLEAR.
  - The result is then a − b in two's complement; bit WIDTH = 1 means no borrow.
  - FLUSH still drives 0/0.
- Not defined: `req_sub` is ignored, `add_cin` is tied to 0, and no sub flag register exists.

## Structure
- Package `serial_add_pkg` holds:
  - the FSM state enum (IDLE, CLEAR, SHIFT, FLUSH, DONE);
  - the bit-count width function;
  - the ID width function.
- Sub-module `rr_arbiter` (parameter `NREQ`) takes `req`, `ptr` and an `advance` input, and outputs a one-hot `grant` plus the encoded winner index.
- Shift registers, FSM and bit counter are all in the top module.

## Test plan
All scenarios use WIDTH=8 and NREQ=2, and include a behavioural `serial_adder` model with a carry clear.
- Add: req0 with a=0x5A, b=0x3C -> `rsp_sum`=0x096, `rsp_id`=0, `rsp_valid` exactly 11 cycles after accept.
- Carry out: a=0xFF, b=0x01 -> `rsp_sum`=0x100. Follow with a=0x00, b=0x00 -> 0x000, which checks that the carry is cleared between words.
- Fairness: req0 and req1 both valid continuously after reset -> grant order 0,1,0,1; each `req_ready` is a single-cycle pulse.
- Backpressure: `rsp_ready` held low for 5 cycles in DONE -> `rsp_valid`, `rsp_sum` and `rsp_id` stay constant, `req_ready` stays 0, and the next accept follows the handshake.
- Reset mid-SHIFT: `rst_n` low at bit 3 -> the next cycle shows IDLE, `rsp_valid`=0 and `ptr`=0. A fresh request 0x01+0x01 -> 0x002.
- With `SERIAL_ADD_CTRL_SUB_EN`:
  - sub=1, a=0x10, b=0x01 -> 0x10F.
  - sub=1, a=0x01, b=0x02 -> 0x0FF (borrow).
